debounce_scheduler: RTL

- Shares one prescaled sample tick and one stability-check datapath across N_CH bouncy inputs (buttons/switches).
- Services channels round-robin, one per tick.
- Each channel has its own small FSM and stability counter; the block produces per-channel debounced levels plus one-cycle edge pulses.
- Sits between the board-level synchronised pins and the user logic (PWM duty steppers, mode selects).

---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_scheduler_if.sv | 30 +++
 rtl/prescale_tick.sv | 25 ++
 rtl/debounce_scheduler.sv | 124 ++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce scheduler and its helpers.
package debounce_pkg;

  typedef enum logic {S_STABLE, S_PENDING} db_state_t;

  // Roughly 1 ms between samples at a 50 MHz clk_sys.
  localparam int DEFAULT_PRESCALE = 49_999;

  function automatic int ptr_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/debounce_scheduler_if.sv
// Control and status bundle of the debounce scheduler.
interface debounce_scheduler_if #(
  parameter int N_CH       = 4,
  parameter int PRESCALE_W = 16,
  parameter int CNT_W      = 4
);
  import debounce_pkg::*;

  localparam int PTR_W = ptr_width(N_CH);

  logic                  ena;
  logic [N_CH-1:0]       bouncy_in;
  logic [PRESCALE_W-1:0] prescale;
  logic [CNT_W-1:0]      bounce_ticks;
  logic [N_CH-1:0]       debounced_out;
  logic [N_CH-1:0]       rise_pulse;
  logic [N_CH-1:0]       fall_pulse;
  logic [PTR_W-1:0]      svc_ptr;

  modport master (
    output ena, bouncy_in, prescale, bounce_ticks,
    input  debounced_out, rise_pulse, fall_pulse, svc_ptr
  );

  modport slave (
    input  ena, bouncy_in, prescale, bounce_ticks,
    output debounced_out, rise_pulse, fall_pulse, svc_ptr
  );

endinterface

// File: rtl/prescale_tick.sv
// Free-running 0..prescale counter producing a one-cycle tick at terminal count.
module prescale_tick #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ena,
  input  logic [W-1:0] i_prescale,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  assign o_tick = i_ena && (r_cnt == i_prescale);

  // A count left above a freshly lowered prescale wraps without ticking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_ena) begin
      r_cnt <= (r_cnt >= i_prescale) ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Round-robin debouncer: one shared compare/count datapath services one channel per tick.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int PRESCALE_W = 16,
  parameter int CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  debounce_scheduler_if.slave  bus
);

  localparam int PTR_W = ptr_width(N_CH);
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(N_CH - 1);

  logic [N_CH-1:0]  r_sync1, r_sync2;
  logic [N_CH-1:0]  r_deb, r_rise, r_fall;
  db_state_t        r_state [N_CH];
  logic [CNT_W-1:0] r_cnt   [N_CH];
  logic [PTR_W-1:0] r_ptr;

  logic             w_tick;
  logic             w_sel_deb, w_mismatch, w_flip;
  db_state_t        w_sel_state, w_nxt_state;
  logic [CNT_W-1:0] w_sel_cnt, w_nxt_cnt;
  logic [CNT_W:0]   w_cnt_inc;

  prescale_tick #(.W(PRESCALE_W)) u_prescale_tick (
    .clk        (clk),
    .rst        (rst),
    .i_ena      (bus.ena),
    .i_prescale (bus.prescale),
    .o_tick     (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.bouncy_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_tick) begin
      r_ptr <= (r_ptr == LAST_CH) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  assign w_sel_deb   = r_deb[r_ptr];
  assign w_sel_state = r_state[r_ptr];
  assign w_sel_cnt   = r_cnt[r_ptr];
  assign w_mismatch  = r_sync2[r_ptr] ^ w_sel_deb;
  assign w_cnt_inc   = {1'b0, w_sel_cnt} + (CNT_W + 1)'(1);

  always_comb begin
    w_nxt_state = w_sel_state;
    w_nxt_cnt   = w_sel_cnt;
    w_flip      = 1'b0;
    case (w_sel_state)
      S_STABLE: begin
        if (!w_mismatch) begin
          w_nxt_cnt = '0;
        end else if (bus.bounce_ticks <= CNT_W'(1)) begin
          w_flip = 1'b1;
        end else begin
          w_nxt_state = S_PENDING;
          w_nxt_cnt   = CNT_W'(1);
        end
      end
      S_PENDING: begin
        if (!w_mismatch) begin
          w_nxt_state = S_STABLE;
          w_nxt_cnt   = '0;
        end else if (w_cnt_inc >= {1'b0, bus.bounce_ticks}) begin
          w_flip = 1'b1;
        end else begin
          w_nxt_cnt = (&w_sel_cnt) ? w_sel_cnt : w_cnt_inc[CNT_W-1:0];
        end
      end
      default: ;
    endcase
    if (w_flip) begin
      w_nxt_state = S_STABLE;
      w_nxt_cnt   = '0;
    end
  end

  // Pulses default low every cycle so they last exactly one clk after a flip.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb  <= '0;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= S_STABLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      if (w_tick) begin
        r_state[r_ptr] <= w_nxt_state;
        r_cnt[r_ptr]   <= w_nxt_cnt;
        if (w_flip) begin
          r_deb[r_ptr]  <= ~w_sel_deb;
          r_rise[r_ptr] <= ~w_sel_deb;
          r_fall[r_ptr] <= w_sel_deb;
        end
      end
    end
  end

  assign bus.debounced_out = r_deb;
  assign bus.rise_pulse    = r_rise;
  assign bus.fall_pulse    = r_fall;
  assign bus.svc_ptr       = r_ptr;

endmodule
